// File: rtl/btn_debounce_multi.sv
// Per-channel button conditioner: N-flop synchroniser, counter debounce, registered rise/fall/edge/long pulses.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES clocks from a stable pin change; no backpressure, outputs always registered.
module btn_debounce_multi #(
   parameter int CH              = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int HOLD_CYCLES     = 0,
   parameter int EDGE_MODE       = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [CH-1:0] signal_in,
   output logic [CH-1:0] level_out,
   output logic [CH-1:0] rise_out,
   output logic [CH-1:0] fall_out,
   output logic [CH-1:0] edge_out,
   output logic [CH-1:0] long_out
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {LOW, RWAIT, HIGH, FWAIT} state_t;

   for (genvar i = 0; i < CH; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   s;
      state_t                 state_q, state_nxt;
      logic [CW-1:0]          cnt_q, cnt_nxt;
      logic                   level_q, level_nxt;
      logic                   rise_q, rise_nxt;
      logic                   fall_q, fall_nxt;
      logic                   edge_q, edge_nxt;

      assign s = sync_q[SYNC_STAGES-1];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sync_q  <= '0;
            state_q <= LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            edge_q  <= 1'b0;
         end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], signal_in[i]};
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            level_q <= level_nxt;
            rise_q  <= rise_nxt;
            fall_q  <= fall_nxt;
            edge_q  <= edge_nxt;
         end
      end

      always_comb begin
         state_nxt = state_q;
         cnt_nxt   = cnt_q;
         level_nxt = level_q;
         rise_nxt  = 1'b0;
         fall_nxt  = 1'b0;
         case (state_q)
            LOW: begin
               if (s) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     state_nxt = HIGH;
                     level_nxt = 1'b1;
                     rise_nxt  = 1'b1;
                  end else begin
                     state_nxt = RWAIT;
                     cnt_nxt   = CW'(1);
                  end
               end
            end
            RWAIT: begin
               if (!s) begin
                  state_nxt = LOW;
                  cnt_nxt   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_nxt = HIGH;
                  cnt_nxt   = '0;
                  level_nxt = 1'b1;
                  rise_nxt  = 1'b1;
               end else begin
                  cnt_nxt = cnt_q + CW'(1);
               end
            end
            HIGH: begin
               if (!s) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     state_nxt = LOW;
                     level_nxt = 1'b0;
                     fall_nxt  = 1'b1;
                  end else begin
                     state_nxt = FWAIT;
                     cnt_nxt   = CW'(1);
                  end
               end
            end
            FWAIT: begin
               if (s) begin
                  state_nxt = HIGH;
                  cnt_nxt   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_nxt = LOW;
                  cnt_nxt   = '0;
                  level_nxt = 1'b0;
                  fall_nxt  = 1'b1;
               end else begin
                  cnt_nxt = cnt_q + CW'(1);
               end
            end
            default: state_nxt = LOW;
         endcase
         edge_nxt = (EDGE_MODE == 0) ? rise_nxt :
                    (EDGE_MODE == 1) ? fall_nxt : (rise_nxt | fall_nxt);
      end

      assign level_out[i] = level_q;
      assign rise_out[i]  = rise_q;
      assign fall_out[i]  = fall_q;
      assign edge_out[i]  = edge_q;

      if (HOLD_CYCLES > 0) begin : g_hold
         localparam logic [HW-1:0] HOLD_SAT = HW'(HOLD_CYCLES);
         localparam logic [HW-1:0] HOLD_M2  = HW'((HOLD_CYCLES >= 2) ? HOLD_CYCLES - 2 : 0);
         logic [HW-1:0] hcnt_q;
         logic          long_q;
         logic          enter_high, stay_high;

         // A glitch excursion into FWAIT still counts as accepted-high time.
         assign enter_high = ((state_q == LOW) || (state_q == RWAIT)) && (state_nxt == HIGH);
         assign stay_high  = ((state_q == HIGH) || (state_q == FWAIT)) && (state_nxt != LOW);

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               hcnt_q <= '0;
               long_q <= 1'b0;
            end else begin
               long_q <= 1'b0;
               if (enter_high) begin
                  hcnt_q <= '0;
                  long_q <= (HOLD_CYCLES == 1);
               end else if (stay_high && (hcnt_q != HOLD_SAT)) begin
                  hcnt_q <= hcnt_q + HW'(1);
                  long_q <= (HOLD_CYCLES >= 2) && (hcnt_q == HOLD_M2);
               end
            end
         end

         assign long_out[i] = long_q;
      end else begin : g_no_hold
         assign long_out[i] = 1'b0;
      end
   end

endmodule
